// File: rtl/piso_bit_feeder_if.sv
// Load handshake and serial outputs of piso_bit_feeder.
// master: upstream word source / sink of the serial stream; slave: the feeder.
interface piso_bit_feeder_if #(
  parameter int unsigned DATA_W = 8
);
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              sdata;
  logic              sbusy;
  logic              frame_done;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready,
    input  sdata,
    input  sbusy,
    input  frame_done
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready,
    output sdata,
    output sbusy,
    output frame_done
  );
endinterface

// File: rtl/piso_bit_feeder.sv
// Parallel-in/serial-out feeder: shifts DATA_W-bit words out LSB-first, one
// bit per clock, holding sdata low between frames. frame_done pulses for one
// cycle after the last serial bit of each frame.
// Build option: define PISO_PARITY_EN to append an even-parity bit after the
// MSB (frame becomes DATA_W+1 bits via the PAR state).
module piso_bit_feeder #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  piso_bit_feeder_if.slave  bus
);

  localparam int unsigned    CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;
`endif

  state_t            state;
  logic [DATA_W-1:0] sh_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              sdata_q;
  logic              sbusy_q;
  logic              done_q;
  logic              last_cyc;
  logic              accept;
`ifdef PISO_PARITY_EN
  logic              par_q;
`endif

  // Last serial cycle of the current frame: the only busy cycle that may accept.
`ifdef PISO_PARITY_EN
  assign last_cyc = (state == PAR);
`else
  assign last_cyc = (state == SHIFT) && (cnt_q == LAST_IDX);
`endif

  assign bus.load_ready = (state == IDLE) || last_cyc;
  assign accept         = bus.load_valid && bus.load_ready;

  assign bus.sdata      = sdata_q;
  assign bus.sbusy      = sbusy_q;
  assign bus.frame_done = done_q;

  // Frame sequencer: capture on accept, shift one bit per clock, then park.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      sdata_q <= 1'b0;
      sbusy_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        // A back-to-back accept still closes the outgoing frame.
        state   <= SHIFT;
        sh_q    <= bus.load_data;
        cnt_q   <= '0;
        sdata_q <= bus.load_data[0];
        sbusy_q <= 1'b1;
        done_q  <= last_cyc;
`ifdef PISO_PARITY_EN
        par_q   <= ^bus.load_data;
`endif
      end else begin
        case (state)
          IDLE: begin
            sdata_q <= 1'b0;
            sbusy_q <= 1'b0;
          end
          SHIFT: begin
            if (cnt_q != LAST_IDX) begin
              sh_q    <= sh_q >> 1;
              sdata_q <= sh_q[1];
              cnt_q   <= cnt_q + CNT_W'(1);
            end else begin
`ifdef PISO_PARITY_EN
              state   <= PAR;
              sdata_q <= par_q;
`else
              state   <= IDLE;
              sdata_q <= 1'b0;
              sbusy_q <= 1'b0;
              done_q  <= 1'b1;
`endif
            end
          end
`ifdef PISO_PARITY_EN
          PAR: begin
            state   <= IDLE;
            sdata_q <= 1'b0;
            sbusy_q <= 1'b0;
            done_q  <= 1'b1;
          end
`endif
          default: begin
            // Unreachable encoding: park with everything cleared.
            state   <= IDLE;
            cnt_q   <= '0;
            sdata_q <= 1'b0;
            sbusy_q <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piso_bit_feeder.sv
// Self-checking bench for piso_bit_feeder (8-bit main instance plus a 4-bit
// instance). Honours PISO_PARITY_EN in its reference model.
module tb_piso_bit_feeder;

  localparam int unsigned W  = 8;
  localparam int unsigned W4 = 4;
`ifdef PISO_PARITY_EN
  localparam int FRAME  = W + 1;
  localparam int FRAME4 = W4 + 1;
`else
  localparam int FRAME  = W;
  localparam int FRAME4 = W4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  piso_bit_feeder_if #(.DATA_W(W))  bus  ();
  piso_bit_feeder_if #(.DATA_W(W4)) bus4 ();

  piso_bit_feeder #(.DATA_W(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  piso_bit_feeder #(.DATA_W(W4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: rem = frame bits still to appear, including this cycle.
  logic q[$];
  int   rem      = 0;
  logic exp_done = 1'b0;
  int   acc_cnt  = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem      <= 0;
      exp_done <= 1'b0;
      q.delete();
    end else begin
      exp_done <= (rem == 1);
      if (bus.load_valid && rem <= 1) begin
        rem     <= FRAME;
        acc_cnt <= acc_cnt + 1;
        for (int i = 0; i < W; i++) q.push_back(bus.load_data[i]);
`ifdef PISO_PARITY_EN
        q.push_back(^bus.load_data);
`endif
      end else if (rem > 0) begin
        rem <= rem - 1;
      end
    end
  end

  // Output monitor: compares every cycle against the model and scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      logic eb;
      check("load_ready", 32'(bus.load_ready), 32'(rem <= 1));
      check("frame_done", 32'(bus.frame_done), 32'(exp_done));
      if (rem > 0) begin
        eb = 1'b0;
        if (q.size() > 0) eb = q.pop_front();
        check("sdata", 32'(bus.sdata), 32'(eb));
        check("sbusy", 32'(bus.sbusy), 32'd1);
      end else begin
        check("sdata_idle", 32'(bus.sdata), 32'd0);
        check("sbusy_idle", 32'(bus.sbusy), 32'd0);
      end
    end
  end

  // Present a word and hold load_valid until the model sees it accepted.
  task automatic send(input logic [W-1:0] d);
    int n0;
    n0 = acc_cnt;
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    for (int k = 0; k < 40 && acc_cnt == n0; k++) @(negedge clk);
    if (acc_cnt == n0) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: word %0h never accepted", d);
    end
  endtask

  // Drop valid and scramble data, which must be ignored.
  task automatic release_bus();
    bus.load_valid = 1'b0;
    bus.load_data  = W'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W4-1:0] w4;
    bus.load_valid  = 1'b0;
    bus.load_data   = '0;
    bus4.load_valid = 1'b0;
    bus4.load_data  = '0;

    // Reset state
    #1;
    check("rst_ready", 32'(bus.load_ready), 32'd1);
    check("rst_sdata", 32'(bus.sdata), 32'd0);
    check("rst_sbusy", 32'(bus.sbusy), 32'd0);
    check("rst_done",  32'(bus.frame_done), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    // Single frame
    @(negedge clk);
    send(8'hA5);
    release_bus();
    repeat (12) @(negedge clk);

    // Back-to-back with valid held
    send(8'hFF);
    send(8'h00);
    release_bus();
    repeat (20) @(negedge clk);

    // Valid asserted while busy
    send(8'h01);
    release_bus();
    repeat (3) @(negedge clk);
    send(8'h3C);
    release_bus();
    repeat (12) @(negedge clk);

    // Reset mid-frame after bit 3
    send(8'hF0);
    release_bus();
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_sdata", 32'(bus.sdata), 32'd0);
    check("midrst_sbusy", 32'(bus.sbusy), 32'd0);
    check("midrst_done",  32'(bus.frame_done), 32'd0);
    check("midrst_ready", 32'(bus.load_ready), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    send(8'h81);
    release_bus();
    repeat (12) @(negedge clk);

    // Random stream with valid held throughout
    for (int n = 0; n < 4; n++) send(W'($urandom));
    release_bus();
    repeat (FRAME + 4) @(negedge clk);

    // 4-bit instance, word 4'hA
    w4 = 4'hA;
    check("w4_ready", 32'(bus4.load_ready), 32'd1);
    bus4.load_valid = 1'b1;
    bus4.load_data  = w4;
    @(negedge clk);
    bus4.load_valid = 1'b0;
    bus4.load_data  = 4'h5;
    for (int i = 0; i < FRAME4; i++) begin
      check("w4_sdata", 32'(bus4.sdata), 32'((i < W4) ? w4[i] : ^w4));
      check("w4_sbusy", 32'(bus4.sbusy), 32'd1);
      check("w4_done",  32'(bus4.frame_done), 32'd0);
      @(negedge clk);
    end
    check("w4_done_pulse", 32'(bus4.frame_done), 32'd1);
    check("w4_sbusy_end",  32'(bus4.sbusy), 32'd0);
    check("w4_sdata_end",  32'(bus4.sdata), 32'd0);
    @(negedge clk);
    check("w4_done_clear", 32'(bus4.frame_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
